dmem_arbiter: RTL and testbench

Shares the single data-memory port (sram_BW64 `addr/wen/ren/wdata/rdata`) between the pipeline MEM stage and the external host port. Replaces the direct hookup of the EX/MEM pipeline register to the SRAM, so the host can load or inspect data memory while the core runs.
- The CPU has priority by default.
- A starvation counter guarantees the host a slot after a bounded wait.
- Read data returns one cycle after issue, tagged to the requester that issued the read.
- The block stalls the pipeline while the CPU is denied.

---
 rtl/dmem_arbiter.sv | 107 ++++++++++
 tb/tb_dmem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the MEM stage and the host share one SRAM port.
// The CPU wins by default; a starvation counter bounds how long the host can wait.
module dmem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ext_req,
    input  logic              ext_wen,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

    localparam logic [3:0] LP_MAX = 4'(STARVE_MAX);

    logic [3:0] r_wait_cnt;
    owner_t     r_rd_owner;
    owner_t     w_owner_nxt;
    logic       w_host_pri;
    logic       w_ext_gnt;
    logic       w_cpu_gnt;

    assign w_host_pri = ext_req && (r_wait_cnt == LP_MAX);
    assign w_ext_gnt  = ext_req && (!cpu_req || w_host_pri);
    assign w_cpu_gnt  = cpu_req && !w_ext_gnt;

    assign cpu_stall  = cpu_req && w_ext_gnt;
    assign ext_gnt    = w_ext_gnt;

    // Route the granted requester onto the SRAM port; idle drives zeros
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        if (w_ext_gnt) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_wen   = ext_wen;
            mem_ren   = !ext_wen;
        end else if (w_cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wen   = cpu_wen;
            mem_ren   = !cpu_wen;
        end
    end

    // Tag the read issued this cycle with its requester
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_ext_gnt && !ext_wen) begin
            w_owner_nxt = OWN_EXT;
        end else if (w_cpu_gnt && !cpu_wen) begin
            w_owner_nxt = OWN_CPU;
        end
    end

    // Count consecutive denied host cycles, saturating at the threshold
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wait_cnt <= 4'd0;
        end else if (!ext_req || w_ext_gnt) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt != LP_MAX) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    // Remember who owns the SRAM data returning next cycle
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rd_owner <= OWN_NONE;
        end else begin
            r_rd_owner <= w_owner_nxt;
        end
    end

    assign cpu_rvalid = (r_rd_owner == OWN_CPU);
    assign ext_rvalid = (r_rd_owner == OWN_EXT);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural one-cycle SRAM.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_dmem_arbiter;

    logic        clk;
    logic        arst_n;
    logic        cpu_req;
    logic        cpu_wen;
    logic [63:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic        cpu_stall;
    logic [63:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        ext_req;
    logic        ext_wen;
    logic [63:0] ext_addr;
    logic [63:0] ext_wdata;
    logic        ext_gnt;
    logic [63:0] ext_rdata;
    logic        ext_rvalid;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wen;
    logic        mem_ren;
    logic [63:0] mem_rdata;

    logic [63:0] sram [0:31];

    int n_cmp = 0;
    int n_bad = 0;

    dmem_arbiter #(
        .ADDR_W(64),
        .DATA_W(64),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .cpu_req(cpu_req),
        .cpu_wen(cpu_wen),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall),
        .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .ext_req(ext_req),
        .ext_wen(ext_wen),
        .ext_addr(ext_addr),
        .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt),
        .ext_rdata(ext_rdata),
        .ext_rvalid(ext_rvalid),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wen(mem_wen),
        .mem_ren(mem_ren),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: write at the edge, read data one cycle after ren
    always @(posedge clk) begin
        if (mem_wen) sram[mem_addr[7:3]] <= mem_wdata;
        if (mem_ren) mem_rdata <= sram[mem_addr[7:3]];
    end

    task automatic idle_inputs();
        cpu_req   = 1'b0;
        cpu_wen   = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        ext_req   = 1'b0;
        ext_wen   = 1'b0;
        ext_addr  = '0;
        ext_wdata = '0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cpu_req  = 1'($urandom_range(0, 1));
            cpu_wen  = 1'($urandom_range(0, 1));
            cpu_addr = 64'h38;
            ext_req  = 1'($urandom_range(0, 1));
            ext_wen  = 1'($urandom_range(0, 1));
            ext_addr = 64'h38;
            #1;
            n_cmp++;
            if (cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold rvalid cpu=%b ext=%b want 0/0",
                         cpu_rvalid, ext_rvalid);
            end
        end
        @(negedge clk);
        idle_inputs();
        arst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (dut.r_wait_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_wait_cnt got %0d want 0", dut.r_wait_cnt);
        end
        n_cmp++;
        if (cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release rvalid cpu=%b ext=%b want 0/0",
                     cpu_rvalid, ext_rvalid);
        end
    endtask

    task automatic test_cpu_only();
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_wen   = 1'b1;
        cpu_addr  = 64'h10;
        cpu_wdata = 64'hDEADBEEF;
        #1;
        n_cmp++;
        if (cpu_stall !== 1'b0 || mem_wen !== 1'b1 || mem_ren !== 1'b0) begin
            n_bad++;
            $display("FAIL cpu_write stall=%b wen=%b ren=%b want 0/1/0",
                     cpu_stall, mem_wen, mem_ren);
        end
        @(negedge clk);
        cpu_wen = 1'b0;
        #1;
        n_cmp++;
        if (cpu_stall !== 1'b0 || mem_ren !== 1'b1 || cpu_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL cpu_read_issue stall=%b ren=%b rvalid=%b want 0/1/0",
                     cpu_stall, mem_ren, cpu_rvalid);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 64'hDEADBEEF) begin
            n_bad++;
            $display("FAIL cpu_read_data rvalid=%b data=%h want 1/deadbeef",
                     cpu_rvalid, cpu_rdata);
        end
        n_cmp++;
        if (ext_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL cpu_only_ext_rvalid got %b want 0", ext_rvalid);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (cpu_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL cpu_rvalid_pulse got %b want 0", cpu_rvalid);
        end
    endtask

    task automatic test_ext_only();
        @(negedge clk);
        ext_req   = 1'b1;
        ext_wen   = 1'b1;
        ext_addr  = 64'h20;
        ext_wdata = 64'h1234;
        #1;
        n_cmp++;
        if (ext_gnt !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== 64'h20) begin
            n_bad++;
            $display("FAIL ext_write gnt=%b wen=%b addr=%h want 1/1/20",
                     ext_gnt, mem_wen, mem_addr);
        end
        @(negedge clk);
        ext_wen = 1'b0;
        #1;
        n_cmp++;
        if (ext_gnt !== 1'b1 || mem_ren !== 1'b1 || ext_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL ext_read_issue gnt=%b ren=%b rvalid=%b want 1/1/0",
                     ext_gnt, mem_ren, ext_rvalid);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if (ext_rvalid !== 1'b1 || ext_rdata !== 64'h1234
            || cpu_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL ext_read_data rvalid=%b data=%h cpu_rv=%b want 1/1234/0",
                     ext_rvalid, ext_rdata, cpu_rvalid);
        end
    endtask

    task automatic test_contention();
        logic exp_gnt;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_wen   = 1'b0;
        cpu_addr  = 64'h10;
        ext_req   = 1'b1;
        ext_wen   = 1'b1;
        ext_addr  = 64'h28;
        ext_wdata = 64'h55;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            exp_gnt = (k == 5);
            n_cmp++;
            if (dut.r_wait_cnt !== 4'(k - 1) || ext_gnt !== exp_gnt
                || cpu_stall !== exp_gnt) begin
                n_bad++;
                $display("FAIL contention_c%0d cnt=%0d gnt=%b stall=%b want %0d/%b/%b",
                         k, dut.r_wait_cnt, ext_gnt, cpu_stall,
                         k - 1, exp_gnt, exp_gnt);
            end
        end
        @(negedge clk);
        ext_req = 1'b0;
        #1;
        n_cmp++;
        if (dut.r_wait_cnt !== 4'd0 || cpu_stall !== 1'b0
            || mem_ren !== 1'b1) begin
            n_bad++;
            $display("FAIL contention_after cnt=%0d stall=%b ren=%b want 0/0/1",
                     dut.r_wait_cnt, cpu_stall, mem_ren);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || mem_addr !== 64'h0
            || mem_wdata !== 64'h0) begin
            n_bad++;
            $display("FAIL idle_port ren=%b wen=%b addr=%h wdata=%h want all 0",
                     mem_ren, mem_wen, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_wen   = 1'b1;
        cpu_addr  = 64'h08;
        cpu_wdata = 64'hA;
        @(negedge clk);
        cpu_addr  = 64'h18;
        cpu_wdata = 64'hB;
        @(negedge clk);
        cpu_wen  = 1'b0;
        cpu_addr = 64'h08;
        @(negedge clk);
        cpu_req  = 1'b0;
        ext_req  = 1'b1;
        ext_wen  = 1'b0;
        ext_addr = 64'h18;
        #1;
        n_cmp++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 64'hA
            || ext_rvalid !== 1'b0 || ext_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_cpu rv=%b data=%h ext_rv=%b gnt=%b want 1/a/0/1",
                     cpu_rvalid, cpu_rdata, ext_rvalid, ext_gnt);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if (ext_rvalid !== 1'b1 || ext_rdata !== 64'hB
            || cpu_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_ext rv=%b data=%h cpu_rv=%b want 1/b/0",
                     ext_rvalid, ext_rdata, cpu_rvalid);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ext_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_tail cpu_rv=%b ext_rv=%b want 0/0",
                     cpu_rvalid, ext_rvalid);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_wen  = 1'b0;
        cpu_addr = 64'h08;
        @(negedge clk);
        idle_inputs();
        arst_n = 1'b0;
        #1;
        n_cmp++;
        if (cpu_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_read_in_reset rvalid=%b want 0", cpu_rvalid);
        end
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_read_after%0d cpu_rv=%b ext_rv=%b want 0/0",
                         i, cpu_rvalid, ext_rvalid);
            end
        end
    endtask

    initial begin
        arst_n    = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 32; i++) sram[i] = '0;
        idle_inputs();
        test_reset();
        test_cpu_only();
        test_ext_only();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
